// File: rtl/brick_serial_mac_if.sv
// Operand/result handshake bundle for brick_serial_mac.
// master = operand feeder / result consumer side, slave = the MAC unit.
interface brick_serial_mac_if #(
  parameter int ACC_W    = 24,
  parameter int MAX_BITS = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [MAX_BITS-1:0] x;
  logic [MAX_BITS-1:0] y;
  logic [1:0]          mode;
  logic                sx;
  logic                sy;
  logic                clear_acc;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    acc_out;
  logic                ovf;

  modport master (
    output in_valid, x, y, mode, sx, sy, clear_acc, out_ready,
    input  in_ready, out_valid, acc_out, ovf
  );

  modport slave (
    input  in_valid, x, y, mode, sx, sy, clear_acc, out_ready,
    output in_ready, out_valid, acc_out, ovf
  );
endinterface

// File: rtl/brick_serial_mac.sv
// Precision-scalable serial MAC: one 2-bit brick product per cycle into a signed accumulator.
// Optional saturating accumulation when BRICK_MAC_SAT_EN is defined; wraps otherwise.
module brick_serial_mac #(
  parameter int ACC_W    = 24,
  parameter int MAX_BITS = 8
) (
  input logic               clock,
  input logic               reset,
  brick_serial_mac_if.slave bus
);

  // Wide enough to hold accumulator plus any shifted brick product without loss.
  localparam int WIDE = ACC_W + 16;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t              state_q;
  logic [MAX_BITS-1:0] x_q;
  logic [MAX_BITS-1:0] y_q;
  logic                sx_q;
  logic                sy_q;
  logic [1:0]          n_last_q;
  logic [1:0]          i_q;
  logic [1:0]          j_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_out_q;
  logic                out_valid_q;
  logic                in_ready_q;
  logic                ovf_q;

  logic [1:0]          x_b;
  logic [1:0]          y_b;
  logic signed [2:0]   xs;
  logic signed [2:0]   ys;
  logic signed [5:0]   prod;
  logic [3:0]          sh;
  logic signed [WIDE-1:0] prod_w;
  logic signed [WIDE-1:0] acc_w;
  logic signed [WIDE-1:0] sum_w;
  logic [ACC_W-1:0]    acc_next;
  logic                sat;
  logic [1:0]          n_last_in;

  always_comb begin
    case (bus.mode)
      2'b00:   n_last_in = 2'd0;
      2'b01:   n_last_in = 2'd1;
      default: n_last_in = 2'd3;
    endcase
  end

  // Only the top brick of each operand carries the sign; lower bricks are magnitudes.
  always_comb begin
    x_b    = 2'(x_q >> {i_q, 1'b0});
    y_b    = 2'(y_q >> {j_q, 1'b0});
    xs     = {sx_q & (i_q == n_last_q) & x_b[1], x_b};
    ys     = {sy_q & (j_q == n_last_q) & y_b[1], y_b};
    prod   = xs * ys;
    sh     = {1'b0, i_q, 1'b0} + {1'b0, j_q, 1'b0};
    prod_w = {{(WIDE-6){prod[5]}}, prod} <<< sh;
    acc_w  = {{(WIDE-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    sum_w  = acc_w + prod_w;
  end

`ifdef BRICK_MAC_SAT_EN
  always_comb begin
    acc_next = sum_w[ACC_W-1:0];
    sat      = 1'b0;
    if (!sum_w[WIDE-1] && (sum_w[WIDE-2:ACC_W-1] != '0)) begin
      acc_next = {1'b0, {(ACC_W-1){1'b1}}};
      sat      = 1'b1;
    end else if (sum_w[WIDE-1] && (sum_w[WIDE-2:ACC_W-1] != '1)) begin
      acc_next = {1'b1, {(ACC_W-1){1'b0}}};
      sat      = 1'b1;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^sum_w[WIDE-1:ACC_W];
  always_comb begin
    acc_next = sum_w[ACC_W-1:0];
    sat      = 1'b0;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      n_last_q    <= '0;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q        <= bus.x;
            y_q        <= bus.y;
            sx_q       <= bus.sx;
            sy_q       <= bus.sy;
            n_last_q   <= n_last_in;
            i_q        <= '0;
            j_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= MUL;
            if (bus.clear_acc) begin
              acc_q     <= '0;
              acc_out_q <= '0;
              ovf_q     <= 1'b0;
            end
          end
        end
        MUL: begin
          acc_q <= acc_next;
          if (sat) ovf_q <= 1'b1;
          if (j_q == n_last_q) begin
            j_q <= '0;
            if (i_q == n_last_q) begin
              acc_out_q   <= acc_next;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              i_q <= i_q + 2'd1;
            end
          end else begin
            j_q <= j_q + 2'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.ovf       = ovf_q;

endmodule
